// File: rtl/hazard_ctrl.sv
// ID/EX producer-side hazard control: load-use stall, taken-branch squash,
// control-bundle bubbling and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_Branch,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_MemtoReg,
  input  logic             id_RegWrite,
  input  logic             id_ALUSrc,
  input  logic [3:0]       id_ALUOp,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_rd,
  input  logic             ex_branch_taken,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             ctl_Branch,
  output logic             ctl_MemRead,
  output logic             ctl_MemWrite,
  output logic             ctl_MemtoReg,
  output logic             ctl_RegWrite,
  output logic             ctl_ALUSrc,
  output logic [3:0]       ctl_ALUOp,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             busy
);

  localparam int unsigned REM_W = 4;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_STALL_CYCLES - 1);
  localparam logic MULTI_STALL = (LOAD_STALL_CYCLES > 1);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [REM_W-1:0] rem, rem_nxt;
  logic             hazard;
  logic             bubble;
  logic             stall_inc;
  logic             flush_inc;

  assign hazard = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                  ((IDEX_rd == id_rs1) || (id_uses_rs2 && (IDEX_rd == id_rs2)));

  // Next state, stall/flush decisions; reset forces the safe output set.
  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    PCWrite    = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    bubble     = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    busy       = (state == STALL);
    case (state)
      RUN: begin
        if (ex_branch_taken) begin
          IFID_Flush = 1'b1;
          bubble     = 1'b1;
          flush_inc  = 1'b1;
        end else if (hazard) begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          bubble     = 1'b1;
          stall_inc  = 1'b1;
          if (MULTI_STALL) begin
            state_nxt = STALL;
            rem_nxt   = REM_INIT;
          end
        end
      end
      STALL: begin
        if (ex_branch_taken) begin
          IFID_Flush = 1'b1;
          bubble     = 1'b1;
          flush_inc  = 1'b1;
          state_nxt  = RUN;
          rem_nxt    = '0;
        end else begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          bubble     = 1'b1;
          stall_inc  = 1'b1;
          rem_nxt    = rem - REM_W'(1);
          if (rem == REM_W'(1)) state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        rem_nxt   = '0;
      end
    endcase
    if (!reset) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
      IFID_Flush = 1'b1;
      bubble     = 1'b1;
      busy       = 1'b0;
    end
  end

  assign ctl_Branch   = id_Branch   & ~bubble;
  assign ctl_MemRead  = id_MemRead  & ~bubble;
  assign ctl_MemWrite = id_MemWrite & ~bubble;
  assign ctl_MemtoReg = id_MemtoReg & ~bubble;
  assign ctl_RegWrite = id_RegWrite & ~bubble;
  assign ctl_ALUSrc   = id_ALUSrc   & ~bubble;
  assign ctl_ALUOp    = bubble ? 4'd0 : id_ALUOp;

  // State and saturating performance counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      rem         <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default, 3-cycle-stall and 4-bit-counter instances.
module tb_hazard_ctrl;

  localparam logic [9:0] PASS = 10'b1010111010;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, IDEX_rd;
  logic       id_uses_rs2, IDEX_MemRead, ex_branch_taken;
  logic       id_Branch, id_MemRead, id_MemWrite, id_MemtoReg, id_RegWrite, id_ALUSrc;
  logic [3:0] id_ALUOp;

  wire        pc1, ifw1, fl1, busy1;
  wire [9:0]  ctl1;
  wire [31:0] sc1, fc1;
  wire        pc3, ifw3, fl3, busy3;
  wire [9:0]  ctl3;
  wire [31:0] sc3, fc3;
  wire        pc4, ifw4, fl4, busy4;
  wire [9:0]  ctl4;
  wire [3:0]  sc4, fc4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl u1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc),
    .id_ALUOp(id_ALUOp), .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
    .ex_branch_taken(ex_branch_taken), .PCWrite(pc1), .IFID_Write(ifw1), .IFID_Flush(fl1),
    .ctl_Branch(ctl1[9]), .ctl_MemRead(ctl1[8]), .ctl_MemWrite(ctl1[7]),
    .ctl_MemtoReg(ctl1[6]), .ctl_RegWrite(ctl1[5]), .ctl_ALUSrc(ctl1[4]),
    .ctl_ALUOp(ctl1[3:0]), .stall_count(sc1), .flush_count(fc1), .busy(busy1));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc),
    .id_ALUOp(id_ALUOp), .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
    .ex_branch_taken(ex_branch_taken), .PCWrite(pc3), .IFID_Write(ifw3), .IFID_Flush(fl3),
    .ctl_Branch(ctl3[9]), .ctl_MemRead(ctl3[8]), .ctl_MemWrite(ctl3[7]),
    .ctl_MemtoReg(ctl3[6]), .ctl_RegWrite(ctl3[5]), .ctl_ALUSrc(ctl3[4]),
    .ctl_ALUOp(ctl3[3:0]), .stall_count(sc3), .flush_count(fc3), .busy(busy3));

  hazard_ctrl #(.CNT_W(4)) u4 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite), .id_ALUSrc(id_ALUSrc),
    .id_ALUOp(id_ALUOp), .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
    .ex_branch_taken(ex_branch_taken), .PCWrite(pc4), .IFID_Write(ifw4), .IFID_Flush(fl4),
    .ctl_Branch(ctl4[9]), .ctl_MemRead(ctl4[8]), .ctl_MemWrite(ctl4[7]),
    .ctl_MemtoReg(ctl4[6]), .ctl_RegWrite(ctl4[5]), .ctl_ALUSrc(ctl4[4]),
    .ctl_ALUOp(ctl4[3:0]), .stall_count(sc4), .flush_count(fc4), .busy(busy4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_Branch, id_MemRead, id_MemWrite, id_MemtoReg, id_RegWrite, id_ALUSrc} = 6'b101011;
    id_ALUOp        = 4'hA;
    id_rs1          = 5'd1;
    id_rs2          = 5'd2;
    id_uses_rs2     = 1'b0;
    IDEX_MemRead    = 1'b0;
    IDEX_rd         = 5'd0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic load_use_rs1();
    IDEX_MemRead = 1'b1;
    IDEX_rd      = 5'd5;
    id_rs1       = 5'd5;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #1;
    total++;
    if ({pc1, ifw1, fl1, busy1, ctl1} !== {4'b0010, 10'd0}) begin
      bad++; $display("FAIL reset_forced got=%b exp=%b", {pc1, ifw1, fl1, busy1, ctl1}, {4'b0010, 10'd0});
    end
    step();
    reset = 1'b1;
    #1;
    total++;
    if ({sc1, fc1, busy1} !== 65'd0) begin
      bad++; $display("FAIL reset_counters sc=%0d fc=%0d busy=%b", sc1, fc1, busy1);
    end
    total++;
    if ({pc1, ifw1, fl1, ctl1} !== {3'b110, PASS}) begin
      bad++; $display("FAIL reset_release got=%b exp=%b", {pc1, ifw1, fl1, ctl1}, {3'b110, PASS});
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    load_use_rs1();
    #1;
    total++;
    if ({pc1, ifw1, fl1, ctl1} !== 13'd0) begin
      bad++; $display("FAIL load_use_rs1 got=%b exp=%b", {pc1, ifw1, fl1, ctl1}, 13'd0);
    end
    step();
    total++;
    if (sc1 !== 32'd1) begin bad++; $display("FAIL load_use_count got=%0d exp=1", sc1); end
    IDEX_MemRead = 1'b0;
    #1;
    total++;
    if ({pc1, ifw1, ctl1} !== {2'b11, PASS}) begin
      bad++; $display("FAIL load_use_after got=%b exp=%b", {pc1, ifw1, ctl1}, {2'b11, PASS});
    end
    step();
  endtask

  task automatic test_no_false_stall();
    apply_reset();
    IDEX_MemRead = 1'b1;
    IDEX_rd      = 5'd0;
    id_rs1       = 5'd0;
    #1;
    total++;
    if ({pc1, ctl1} !== {1'b1, PASS}) begin
      bad++; $display("FAIL x0_no_stall got=%b exp=%b", {pc1, ctl1}, {1'b1, PASS});
    end
    IDEX_rd     = 5'd7;
    id_rs1      = 5'd3;
    id_rs2      = 5'd7;
    id_uses_rs2 = 1'b0;
    #1;
    total++;
    if ({pc1, ctl1} !== {1'b1, PASS}) begin
      bad++; $display("FAIL rs2_unused got=%b exp=%b", {pc1, ctl1}, {1'b1, PASS});
    end
    id_uses_rs2 = 1'b1;
    #1;
    total++;
    if ({pc1, ifw1, ctl1} !== 12'd0) begin
      bad++; $display("FAIL rs2_used got=%b exp=%b", {pc1, ifw1, ctl1}, 12'd0);
    end
    step();
    total++;
    if (sc1 !== 32'd1) begin bad++; $display("FAIL rs2_count got=%0d exp=1", sc1); end
  endtask

  task automatic test_branch_vs_hazard();
    apply_reset();
    load_use_rs1();
    ex_branch_taken = 1'b1;
    #1;
    total++;
    if ({pc1, ifw1, fl1, ctl1} !== {3'b111, 10'd0}) begin
      bad++; $display("FAIL branch_hazard got=%b exp=%b", {pc1, ifw1, fl1, ctl1}, {3'b111, 10'd0});
    end
    step();
    total++;
    if ({fc1, sc1} !== {32'd1, 32'd0}) begin
      bad++; $display("FAIL branch_counts fc=%0d sc=%0d exp fc=1 sc=0", fc1, sc1);
    end
    total++;
    if (busy3 !== 1'b0) begin bad++; $display("FAIL branch_no_stall3 busy=%b exp=0", busy3); end
  endtask

  task automatic test_multi_stall();
    apply_reset();
    load_use_rs1();
    #1;
    total++;
    if ({pc3, busy3} !== 2'b00) begin bad++; $display("FAIL ms_c1 got=%b exp=00", {pc3, busy3}); end
    step();
    IDEX_MemRead = 1'b0;
    #1;
    total++;
    if ({pc3, ifw3, busy3, ctl3} !== {3'b001, 10'd0}) begin
      bad++; $display("FAIL ms_c2 got=%b exp=%b", {pc3, ifw3, busy3, ctl3}, {3'b001, 10'd0});
    end
    step();
    total++;
    if ({pc3, busy3} !== 2'b01) begin bad++; $display("FAIL ms_c3 got=%b exp=01", {pc3, busy3}); end
    step();
    total++;
    if ({pc3, busy3, ctl3} !== {2'b10, PASS}) begin
      bad++; $display("FAIL ms_done got=%b exp=%b", {pc3, busy3, ctl3}, {2'b10, PASS});
    end
    total++;
    if (sc3 !== 32'd3) begin bad++; $display("FAIL ms_count got=%0d exp=3", sc3); end
  endtask

  task automatic test_stall_abort();
    apply_reset();
    load_use_rs1();
    step();
    IDEX_MemRead    = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    total++;
    if ({pc3, fl3, busy3, ctl3} !== {3'b111, 10'd0}) begin
      bad++; $display("FAIL abort_out got=%b exp=%b", {pc3, fl3, busy3, ctl3}, {3'b111, 10'd0});
    end
    step();
    ex_branch_taken = 1'b0;
    #1;
    total++;
    if ({busy3, pc3, sc3, fc3} !== {2'b01, 32'd1, 32'd1}) begin
      bad++; $display("FAIL abort_state busy=%b pc=%b sc=%0d fc=%0d exp 0 1 1 1", busy3, pc3, sc3, fc3);
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    load_use_rs1();
    step();
    IDEX_MemRead = 1'b0;
    reset        = 1'b0;
    #1;
    total++;
    if ({pc3, ifw3, fl3, busy3, ctl3} !== {4'b0010, 10'd0}) begin
      bad++; $display("FAIL rms_forced got=%b exp=%b", {pc3, ifw3, fl3, busy3, ctl3}, {4'b0010, 10'd0});
    end
    step();
    reset = 1'b1;
    #1;
    total++;
    if ({busy3, pc3, ctl3, sc3} !== {2'b01, PASS, 32'd0}) begin
      bad++; $display("FAIL rms_after busy=%b pc=%b ctl=%b sc=%0d", busy3, pc3, ctl3, sc3);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    load_use_rs1();
    repeat (14) step();
    total++;
    if (sc4 !== 4'd14) begin bad++; $display("FAIL sat_pre got=%0d exp=14", sc4); end
    repeat (6) step();
    total++;
    if (sc4 !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", sc4); end
    total++;
    if (sc1 !== 32'd20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", sc1); end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch_vs_hazard();
    test_multi_stall();
    test_stall_abort();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Producer-side control for the ID/EX pipeline register in the 64-bit five-stage pipeline.
- Detects load-use hazards between the instruction in EX (taken from the ID/EX outputs) and the instruction in ID, and stalls PC and IF/ID when one is found.
- Squashes wrong-path instructions when EX resolves a branch as taken.
- Inserts bubbles by zeroing the control bundle before it enters ID/EX, and keeps stall/flush performance counters.

Parameters:
- LOAD_STALL_CYCLES, 1: bubble cycles inserted per load-use hazard (1..15). Values >1 support slow data memory.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs2  in  1  ID instruction reads rs2 (R/S/B types)
- id_Branch, id_MemRead, id_MemWrite, id_MemtoReg, id_RegWrite, id_ALUSrc  in  1 each  decoder control bits
- id_ALUOp  in  4  decoder ALU op
- IDEX_MemRead  in  1  ID/EX stage holds a load
- IDEX_rd  in  5  destination of the instruction in EX
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- PCWrite  out  1  PC update enable
- IFID_Write  out  1  IF/ID load enable
- IFID_Flush  out  1  IF/ID clear (instruction becomes NOP)
- ctl_Branch, ctl_MemRead, ctl_MemWrite, ctl_MemtoReg, ctl_RegWrite, ctl_ALUSrc  out  1 each  gated control bits to ID/EX
- ctl_ALUOp  out  4  gated ALU op to ID/EX
- stall_count  out  CNT_W  total stall cycles
- flush_count  out  CNT_W  total taken-branch flushes
- busy  out  1  FSM in STALL state

Behaviour:
- hazard = IDEX_MemRead && IDEX_rd!=0 && (IDEX_rd==id_rs1 || (id_uses_rs2 && IDEX_rd==id_rs2)).
- bubble: all ctl_* = 0. Otherwise ctl_* = id_* passthrough. All ctl_* are combinational, zero latency.
- FSM states RUN, STALL. Registers: state, 4-bit remaining-cycle counter rem, stall_count, flush_count.
- RUN, priority 1 (ex_branch_taken=1):
  - PCWrite=1, IFID_Write=1, IFID_Flush=1, bubble.
  - flush_count+1. Next state RUN. Hazard ignored because the ID instruction is wrong-path.
- RUN, priority 2 (hazard=1):
  - PCWrite=0, IFID_Write=0, IFID_Flush=0, bubble, stall_count+1.
  - If LOAD_STALL_CYCLES==1, stay RUN. Else go STALL with rem=LOAD_STALL_CYCLES-1.
- RUN, otherwise: PCWrite=1, IFID_Write=1, IFID_Flush=0, passthrough.
- STALL, no branch: PCWrite=0, IFID_Write=0, bubble, stall_count+1, rem-1. Return to RUN when rem==1 at this edge.
- STALL with ex_branch_taken=1: handled as in RUN priority 1 (flush, flush_count+1). Stall aborted, next state RUN, rem=0.
- The hazard input is not re-evaluated while in STALL.
- busy=1 iff state==STALL.
- Counters saturate at all-ones and never wrap. When stall and flush would both increment, only the action taken counts: flush wins.
- Reset (reset=0 at a rising edge): state=RUN, rem=0, stall_count=0, flush_count=0.
- Reset takes effect at that edge even mid-STALL.
- While reset=0 is applied, outputs are forced: PCWrite=0, IFID_Write=0, IFID_Flush=1, all ctl_*=0, busy=0.
- Counters change only on rising clk. Each stall cycle is counted exactly once.

Test Plan:
- Load-use on rs1: IDEX_MemRead=1, IDEX_rd=5, id_rs1=5 -> that cycle PCWrite=0, IFID_Write=0, ctl_*=0, stall_count 0->1. Next cycle (IDEX_MemRead=0) -> passthrough, PCWrite=1.
- No false stalls: IDEX_rd=0 with id_rs1=0 -> no stall. IDEX_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall. id_uses_rs2=1 -> stall.
- Simultaneous branch and hazard: ex_branch_taken=1 with hazard=1 -> IFID_Flush=1, PCWrite=1, bubble, flush_count+1, stall_count unchanged.
- LOAD_STALL_CYCLES=3: one hazard cycle -> PCWrite=0 for exactly 3 cycles, busy=1 for cycles 2-3, stall_count=3, then passthrough.
- Reset mid-STALL: LOAD_STALL_CYCLES=3, reset=0 in stall cycle 2 -> after the edge state=RUN, counters=0. Outputs forced to reset values while reset=0; normal passthrough resumes after release.
- Saturation: CNT_W=4, 20 hazard cycles -> stall_count holds at 15.
